ffjk_reg_bank: RTL

Parametrised bank of WIDTH JK flip-flops sharing one clock, with per-bit J/K control, synchronous preset, parallel load and a synchronous up/down counting mode built from JK toggle logic. It is the multi-bit successor to the single JK flip-flop. It serves as a general register, event latch or counter in the digital-electronics lab designs.

---
 rtl/ffjk_reg_bank_if.sv | 26 ++
 rtl/ffjk_reg_bank.sv | 92 +++++++++
 2 files changed

// File: rtl/ffjk_reg_bank_if.sv
// Bus bundle for ffjk_reg_bank: control and data inputs, register state and status outputs.
// The master drives controls and data; the slave (the register bank) drives state and status.
interface ffjk_reg_bank_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             preset;
   logic [1:0]       mode;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qn;
   logic             tc;
   logic             changed;

   modport master (
      output en, preset, mode, j, k, d,
      input  Q, Qn, tc, changed
   );

   modport slave (
      input  en, preset, mode, j, k, d,
      output Q, Qn, tc, changed
   );
endinterface

// File: rtl/ffjk_reg_bank.sv
// WIDTH-bit JK flip-flop bank: per-bit JK, parallel load, preset and synchronous up/down count.
// Define FFJK_SATURATE_EN to make the counting modes stop at their terminal states instead of wrapping.
module ffjk_reg_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input logic            clk,
   input logic            reset,
   ffjk_reg_bank_if.slave bus
);

   localparam logic [1:0] MODE_JK   = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_UP   = 2'b10;
   localparam logic [1:0] MODE_DN   = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic             r_changed;

   logic [WIDTH-1:0] w_up_t;
   logic [WIDTH-1:0] w_dn_t;
   logic             w_all1;
   logic             w_all0;
   logic [WIDTH-1:0] w_jk;
   logic [WIDTH-1:0] w_mode_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_q_ones;
   logic             w_q_zero;

   assign w_q_ones = &r_q;
   assign w_q_zero = ~|r_q;

   // Toggle enables of a synchronous JK counter: bit i toggles when all lower bits are ones (up) or zeros (down).
   always_comb begin
      w_up_t = '0;
      w_dn_t = '0;
      w_all1 = 1'b1;
      w_all0 = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         w_up_t[i] = w_all1;
         w_dn_t[i] = w_all0;
         w_all1    = w_all1 & r_q[i];
         w_all0    = w_all0 & ~r_q[i];
      end
   end

   // JK characteristic equation per bit: Q+ = J & ~Q | ~K & Q.
   assign w_jk = (bus.j & ~r_q) | (~bus.k & r_q);

   always_comb begin
      w_mode_next = r_q;
      unique case (bus.mode)
         MODE_JK:   w_mode_next = w_jk;
         MODE_LOAD: w_mode_next = bus.d;
`ifdef FFJK_SATURATE_EN
         MODE_UP:   w_mode_next = w_q_ones ? r_q : (r_q ^ w_up_t);
         MODE_DN:   w_mode_next = w_q_zero ? r_q : (r_q ^ w_dn_t);
`else
         MODE_UP:   w_mode_next = r_q ^ w_up_t;
         MODE_DN:   w_mode_next = r_q ^ w_dn_t;
`endif
         default:   w_mode_next = r_q;
      endcase
   end

   always_comb begin
      if (bus.preset) begin
         w_q_next = {WIDTH{1'b1}};
      end else if (!bus.en) begin
         w_q_next = r_q;
      end else begin
         w_q_next = w_mode_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q       <= RESET_VAL;
         r_changed <= 1'b0;
      end else begin
         r_q       <= w_q_next;
         r_changed <= (w_q_next != r_q);
      end
   end

   assign bus.Q       = r_q;
   assign bus.Qn      = ~r_q;
   assign bus.changed = r_changed;
   assign bus.tc      = ((bus.mode == MODE_UP) && w_q_ones) ||
                        ((bus.mode == MODE_DN) && w_q_zero);

endmodule
